// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display. A shadow bank takes writes from the command
// path; it is copied to the displayed bank only at frame boundaries.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int AW     = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              commit,
  input  logic [DIGITS-1:0] digit_en,
  output logic [3:0]        dec_data,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0] DIG_CNT = (AW+1)'(DIGITS);

  logic [PW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     slot_q, slot_d;
  logic [3:0]        shadow_q [DIGITS];
  logic [3:0]        shadow_d [DIGITS];
  logic [3:0]        active_q [DIGITS];
  logic [3:0]        active_d [DIGITS];
  logic              pending_q, pending_d;
  logic [3:0]        dec_q, dec_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic              pc_wrap;
  logic              slot_last;
  logic              boundary;
  logic              commit_now;
  logic [AW-1:0]     slot_nxt;
  logic              slot_show;

  assign wr_ready   = ~pending_q;
  assign dec_data   = dec_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] lzb_show;

  // Digit i>0 is shown only if it or some higher digit of the active bank is non-zero.
  always_comb begin : lzb_eval
    logic nz_above;
    int unsigned idx;
    nz_above = 1'b0;
    lzb_show = '0;
    idx      = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx = DIGITS - 1 - k;
      nz_above = nz_above | (|active_q[idx]);
      lzb_show[idx] = nz_above || (idx == 0);
    end
  end

  assign slot_show = lzb_show[slot_q];
`else
  assign slot_show = 1'b1;
`endif

  // Scan sequencing, shadow writes, commit handshake and bank copy.
  always_comb begin
    pc_wrap    = (pc_q == PW'(DIV - 1));
    slot_last  = (slot_q == AW'(DIGITS - 1));
    boundary   = pc_wrap && slot_last;
    commit_now = boundary && pending_q;
    slot_nxt   = slot_last ? '0 : slot_q + AW'(1);

    pc_d         = pc_wrap ? '0 : pc_q + PW'(1);
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    dec_d        = dec_q;
    an_d         = an_q;
    frame_done_d = boundary;

    if (wr_valid && !pending_q && ({1'b0, wr_addr} < DIG_CNT)) begin
      shadow_d[wr_addr] = wr_data;
    end

    // A pending copy retires at the boundary; a commit arriving in that same
    // cycle (with nothing pending) arms the next frame's copy instead.
    if (commit_now) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (commit && !pending_q) begin
      pending_d = 1'b1;
    end

    if (pc_wrap) begin
      slot_d = slot_nxt;
      dec_d  = commit_now ? shadow_q[slot_nxt] : active_q[slot_nxt];
      an_d   = '1;
    end else if (pc_q == '0) begin
      an_d = '1;
      if (digit_en[slot_q] && slot_show) begin
        an_d[slot_q] = 1'b0;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      slot_q       <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q    <= 1'b0;
      dec_q        <= '0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      dec_q        <= dec_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
